rr_packet_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter that shares one router output port among N_REQ input requesters.
- Grants one requester, holds the grant until that requester's tail flit transfers, then rotates priority.
- Sits between input-buffer request logic and the output crossbar select and valid signals.
- All state is held in asynchronously reset flops, clocked on CK.

---
 rtl/rr_packet_arbiter.sv | 129 ++++++++++++
 tb/tb_rr_packet_arbiter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_packet_arbiter.sv
// rtl/rr_packet_arbiter.sv - round-robin packet-locked output-port arbiter
// Optional watchdog release is built only when ARB_WATCHDOG_EN is defined.
module rr_packet_arbiter #(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int WD_LIMIT = 15
) (
    input  logic             CK,
    input  logic             RST,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] tail,
    input  logic             out_ready,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             gnt_valid,
    output logic             xfer,
    output logic             wd_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    if (N_REQ < 2 || N_REQ > 16 || (1 << ID_W) < N_REQ || WD_LIMIT < 1 || WD_LIMIT > 255) begin : g_cfg_err
        $error("rr_packet_arbiter: unsupported parameter combination");
    end

    state_t           state_q;
    logic [N_REQ-1:0] gnt_q;
    logic [ID_W-1:0]  gnt_id_q;
    logic             gnt_valid_q;
    logic [ID_W-1:0]  ptr_q;

    logic [ID_W-1:0]  win_id_d;
    logic             win_found_d;
    logic [ID_W:0]    scan_idx;
    logic [ID_W-1:0]  ptr_d;
    logic             owner_req;
    logic             owner_tail;
    logic             release_d;
    logic             wd_fire;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        win_id_d    = '0;
        win_found_d = 1'b0;
        scan_idx    = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            scan_idx = {1'b0, ptr_q} + (ID_W + 1)'(k);
            if (scan_idx >= (ID_W + 1)'(N_REQ)) begin
                scan_idx = scan_idx - (ID_W + 1)'(N_REQ);
            end
            if (req[scan_idx[ID_W-1:0]]) begin
                win_id_d    = scan_idx[ID_W-1:0];
                win_found_d = 1'b1;
            end
        end
    end

    assign owner_req  = req[gnt_id_q];
    assign owner_tail = tail[gnt_id_q];
    assign xfer       = gnt_valid_q & owner_req & out_ready;
    assign ptr_d      = (gnt_id_q == ID_W'(N_REQ - 1)) ? '0 : gnt_id_q + 1'b1;
    assign release_d  = (xfer & owner_tail) | wd_fire;

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (win_found_d) begin
                        state_q     <= LOCKED;
                        gnt_q       <= N_REQ'(1) << win_id_d;
                        gnt_id_q    <= win_id_d;
                        gnt_valid_q <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (release_d) begin
                        state_q     <= IDLE;
                        gnt_q       <= '0;
                        gnt_id_q    <= '0;
                        gnt_valid_q <= 1'b0;
                        ptr_q       <= ptr_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ARB_WATCHDOG_EN
    logic [7:0] wd_cnt_q;
    logic       wd_err_q;

    // Counts consecutive locked cycles in which the owner has no flit.
    assign wd_fire = (state_q == LOCKED) && (wd_cnt_q >= 8'(WD_LIMIT));

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            wd_cnt_q <= '0;
            wd_err_q <= 1'b0;
        end else begin
            wd_err_q <= wd_fire;
            if (state_q != LOCKED || owner_req || wd_fire) begin
                wd_cnt_q <= '0;
            end else begin
                wd_cnt_q <= wd_cnt_q + 8'd1;
            end
        end
    end

    assign wd_err = wd_err_q;
`else
    assign wd_fire = 1'b0;
    assign wd_err  = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// tb/tb_rr_packet_arbiter.sv - self-checking bench for rr_packet_arbiter
module tb_rr_packet_arbiter;

    localparam int N   = 4;
    localparam int IDW = 2;
    localparam int WDL = 15;

    logic           CK = 1'b0;
    logic           RST;
    logic [N-1:0]   req;
    logic [N-1:0]   tail;
    logic           out_ready;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           gnt_valid;
    logic           xfer;
    logic           wd_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CK = ~CK;

    rr_packet_arbiter #(.N_REQ(N), .ID_W(IDW), .WD_LIMIT(WDL)) dut (
        .CK(CK), .RST(RST), .req(req), .tail(tail), .out_ready(out_ready),
        .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .xfer(xfer), .wd_err(wd_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: packet-level view of who owns the port and where priority starts.
    int m_locked, m_owner, m_ptr, m_cnt, m_wd, m_last_xfer;

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_wd = 0; m_last_xfer = 0;
    endtask

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    logic [N-1:0]   s_gnt;
    logic [IDW-1:0] s_id;
    logic           s_valid, s_xfer, s_wd;

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] t, input logic rdy);
        int w;
        int fire;
        logic [N-1:0] exp_gnt;
        req = r; tail = t; out_ready = rdy;
        #4;
        s_gnt = gnt; s_id = gnt_id; s_valid = gnt_valid; s_xfer = xfer; s_wd = wd_err;
        exp_gnt = m_locked ? (N'(1) << m_owner) : '0;
        m_last_xfer = (m_locked != 0 && r[m_owner] && rdy) ? 1 : 0;
        check("gnt", 32'(s_gnt), 32'(exp_gnt));
        check("gnt_id", 32'(s_id), m_locked ? m_owner : 0);
        check("gnt_valid", 32'(s_valid), m_locked);
        check("xfer", 32'(s_xfer), m_last_xfer);
        check("wd_err", 32'(s_wd), m_wd);
        fire = 0;
`ifdef ARB_WATCHDOG_EN
        fire  = (m_locked != 0 && m_cnt >= WDL) ? 1 : 0;
        m_cnt = (m_locked == 0 || r[m_owner] || fire != 0) ? 0 : m_cnt + 1;
`endif
        m_wd = fire;
        if (m_locked == 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_locked = 1;
                m_owner  = w;
            end
        end else if (fire != 0 || (m_last_xfer != 0 && t[m_owner])) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
        end
        @(posedge CK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; req = '0; tail = '0; out_ready = 1'b0;
        @(posedge CK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic [N-1:0]   req;
        logic [N-1:0]   tail;
        logic           rdy;
        logic [N-1:0]   gnt;
        logic [IDW-1:0] id;
        logic           valid;
        logic           xf;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int ids[$];
        int lens[$];
        int exp_ids[5];
        int run, flits, wd_pulses;
        logic prev;
        logic [N-1:0] t;
        logic [N-1:0] r;

        // Single-flit packets from requesters 1 and 3 alternate with an idle cycle between.
        vecs[0] = '{4'b1010, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[2] = '{4'b1010, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[3] = '{4'b1010, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
        vecs[4] = '{4'b1010, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[5] = '{4'b1010, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 1'b1};
        vecs[6] = '{4'b1010, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 1'b0};
        vecs[7] = '{4'b1010, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 1'b1};
        exp_ids = '{0, 1, 2, 3, 0};

        RST = 1'b1; req = '0; tail = '0; out_ready = 1'b0;
        #3;
        check("reset_gnt", 32'(gnt), 0);
        check("reset_valid", 32'(gnt_valid), 0);
        check("reset_wd_err", 32'(wd_err), 0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            req = vecs[i].req; tail = vecs[i].tail; out_ready = vecs[i].rdy;
            #4;
            check($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(vecs[i].gnt));
            check($sformatf("vec%0d_id", i), 32'(gnt_id), 32'(vecs[i].id));
            check($sformatf("vec%0d_valid", i), 32'(gnt_valid), 32'(vecs[i].valid));
            check($sformatf("vec%0d_xfer", i), 32'(xfer), 32'(vecs[i].xf));
            @(posedge CK);
            #1;
        end

        // All requesting, 3-flit packets: strict rotation, 3 cycles per grant.
        do_reset();
        run = 0; flits = 0; prev = 1'b0;
        for (int c = 0; c < 21; c++) begin
            t = (m_locked != 0 && flits == 2) ? '1 : '0;
            step(4'b1111, t, 1'b1);
            if (m_last_xfer != 0) flits = (flits == 2) ? 0 : flits + 1;
            if (s_valid && !prev) ids.push_back(int'(s_id));
            if (s_valid) run++;
            if (!s_valid && prev) begin
                lens.push_back(run);
                run = 0;
            end
            prev = s_valid;
        end
        check("rot_ngrants", ids.size(), 5);
        check("rot_nruns", lens.size(), 5);
        for (int i = 0; i < 5 && i < ids.size(); i++) check($sformatf("rot_id%0d", i), ids[i], exp_ids[i]);
        for (int i = 0; i < 5 && i < lens.size(); i++) check($sformatf("rot_len%0d", i), lens[i], 3);

        // Backpressure holds the grant without moving flits.
        do_reset();
        step(4'b0100, 4'b0100, 1'b0);
        for (int c = 0; c < 5; c++) begin
            step(4'b0100, 4'b0100, 1'b0);
            check("bp_id", 32'(s_id), 2);
            check("bp_xfer", 32'(s_xfer), 0);
        end
        step(4'b0100, 4'b0100, 1'b1);
        check("bp_tail_xfer", 32'(s_xfer), 1);
        step(4'b0000, 4'b0000, 1'b1);
        check("bp_released", 32'(s_valid), 0);

        // Owner bubble mid-packet must not hand the port to requester 1.
        do_reset();
        step(4'b0011, 4'b0000, 1'b1);
        step(4'b0011, 4'b0000, 1'b1);
        for (int c = 0; c < 3; c++) begin
            step(4'b0010, 4'b0000, 1'b1);
            check("bubble_id", 32'(s_id), 0);
            check("bubble_valid", 32'(s_valid), 1);
        end
        step(4'b0011, 4'b0001, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        step(4'b0010, 4'b0000, 1'b1);
        check("bubble_next_id", 32'(s_id), 1);

        // Asynchronous reset while locked, then priority restarts at 0.
        do_reset();
        step(4'b0100, 4'b0000, 1'b1);
        step(4'b0100, 4'b0000, 1'b1);
        #2;
        RST = 1'b1;
        #1;
        check("async_gnt", 32'(gnt), 0);
        check("async_valid", 32'(gnt_valid), 0);
        @(posedge CK);
        #1;
        RST = 1'b0;
        model_reset();
        step(4'b1001, 4'b0000, 1'b1);
        step(4'b1001, 4'b0000, 1'b1);
        check("post_reset_id", 32'(s_id), 0);

        // Owner goes silent for 20 cycles.
        do_reset();
        wd_pulses = 0;
        step(4'b0010, 4'b0000, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(4'b0000, 4'b0000, 1'b1);
            if (s_wd) wd_pulses++;
        end
        step(4'b1010, 4'b0000, 1'b1);
        if (s_wd) wd_pulses++;
        step(4'b1010, 4'b0000, 1'b1);
`ifdef ARB_WATCHDOG_EN
        check("wd_pulses", wd_pulses, 1);
        check("wd_next_id", 32'(s_id), 3);
`else
        check("wd_pulses", wd_pulses, 0);
        check("wd_held_id", 32'(s_id), 1);
        check("wd_held_valid", 32'(s_valid), 1);
`endif

        // Random traffic against the model.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int b = 0; b < N; b++) begin
                r[b] = ($urandom_range(0, 9) < 6);
                t[b] = ($urandom_range(0, 9) < 3);
            end
            step(r, t, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
